adder_error_sweeper: RTL and testbench

Self-timed sweep controller for characterising an approximate adder in hardware. It drives every (a, b) operand pair into an external combinational approximate adder and compares each returned sum against an internal exact sum. It accumulates the raw metrics from which software derives ER, MED and MEP-style figures. It sits beside the adder under test on the characterisation wrapper and replaces the exhaustive simulation loop with a synthesizable engine.

---
 rtl/adder_error_sweeper_pkg.sv | 41 ++++
 rtl/adder_error_sweeper_accum.sv | 61 ++++++
 rtl/adder_error_sweeper.sv | 127 ++++++++++++
 tb/tb_adder_error_sweeper.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_error_sweeper_pkg.sv
// ============================================================================
// Module      : adder_eval_pkg
// Description : Shared state encoding and width helpers for the approximate
//               adder error sweeper, its accumulator and its wrappers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_eval_pkg;

    // Sweep controller state encoding
    typedef logic [1:0] sweep_state_t;

    localparam sweep_state_t c_ST_IDLE  = 2'd0;
    localparam sweep_state_t c_ST_SWEEP = 2'd1;
    localparam sweep_state_t c_ST_FLUSH = 2'd2;
    localparam sweep_state_t c_ST_DONE  = 2'd3;

    // Sum returned by the adder under test carries one extra bit
    function automatic int sum_width(input int w);
        return w + 1;
    endfunction

    // |exact - approx| never exceeds 2**(w+1)-1
    function automatic int err_width(input int w);
        return w + 1;
    endfunction

    // 2**(2w) pairs, each contributing at most 2**(w+1)-1
    function automatic int total_width(input int w);
        return 3 * w + 1;
    endfunction

    // Must be able to hold the full pair count 2**(2w)
    function automatic int count_width(input int w);
        return 2 * w + 1;
    endfunction

endpackage : adder_eval_pkg

`default_nettype wire

// File: rtl/adder_error_sweeper_accum.sv
// ============================================================================
// Module      : sweep_err_accum
// Description : Second pipeline stage of the error sweeper: accumulates the
//               total error, counts erroneous pairs and tracks the maximum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sweep_err_accum
    import adder_eval_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               valid,
    input  logic [WIDTH:0]     err,
    output logic [3*WIDTH:0]   total_err,
    output logic [2*WIDTH:0]   err_cases,
    output logic [WIDTH:0]     max_err
);

    localparam int c_EW = err_width(WIDTH);
    localparam int c_TW = total_width(WIDTH);
    localparam int c_CW = count_width(WIDTH);

    logic [c_TW-1:0] r_total;
    logic [c_CW-1:0] r_cases;
    logic [c_EW-1:0] r_max;

    logic [c_TW-1:0] w_err_ext;
    logic [c_CW-1:0] w_one;

    assign w_err_ext = {{(c_TW - c_EW){1'b0}}, err};
    assign w_one     = {{(c_CW - 1){1'b0}}, 1'b1};

    // Accumulate each valid error sample; widths are sized so nothing wraps
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_total <= '0;
            r_cases <= '0;
            r_max   <= '0;
        end else if (valid) begin
            r_total <= r_total + w_err_ext;
            if (err != '0) begin
                r_cases <= r_cases + w_one;
            end
            if (err > r_max) begin
                r_max <= err;
            end
        end
    end

    assign total_err = r_total;
    assign err_cases = r_cases;
    assign max_err   = r_max;

endmodule : sweep_err_accum

`default_nettype wire

// File: rtl/adder_error_sweeper.sv
// ============================================================================
// Module      : adder_error_sweeper
// Description : Self-timed exhaustive sweep of an external approximate adder.
//               Drives every (a, b) pair, compares the returned sum with the
//               exact sum and accumulates ER / MED / MEP raw metrics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_error_sweeper
    import adder_eval_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    output logic [WIDTH-1:0]   a_o,
    output logic [WIDTH-1:0]   b_o,
    input  logic [WIDTH:0]     approx_sum_i,
    output logic               busy,
    output logic               done,
    output logic [3*WIDTH:0]   total_err,
    output logic [2*WIDTH:0]   err_cases,
    output logic [WIDTH:0]     max_err
);

    localparam int c_SW = sum_width(WIDTH);
    localparam int c_EW = err_width(WIDTH);

    sweep_state_t r_state;
    sweep_state_t w_state_nxt;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] w_idx_nxt;

    logic               r_valid_q;
    logic [c_EW-1:0]    r_err_q;

    logic [c_SW-1:0]    w_exact;
    logic [c_EW-1:0]    w_err;

    logic               w_start_acc;
    logic               w_sample;
    logic               w_last;

    // start only counts when the engine is idle or parked in DONE
    assign w_start_acc = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_sample    = (r_state == c_ST_SWEEP) && !stall;
    assign w_last      = w_sample && (&r_a) && (&r_b);

    // Exact reference sum and absolute difference, both WIDTH+1 bits
    assign w_exact = {1'b0, r_a} + {1'b0, r_b};
    assign w_err   = (w_exact >= approx_sum_i) ? (w_exact - approx_sum_i)
                                               : (approx_sum_i - w_exact);

    // b is the low half so a single increment gives a-outer, b-inner order
    assign w_idx_nxt = {r_a, r_b} + {{(2*WIDTH-1){1'b0}}, 1'b1};

    // Next-state logic for the sweep controller
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (start)  w_state_nxt = c_ST_SWEEP;
            c_ST_SWEEP: if (w_last) w_state_nxt = c_ST_FLUSH;
            c_ST_FLUSH: w_state_nxt = c_ST_DONE;
            c_ST_DONE:  if (start)  w_state_nxt = c_ST_SWEEP;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand index counter; holds at all ones after the last pair
    always_ff @(posedge clk) begin
        if (!rst_n || w_start_acc) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_sample && !w_last) begin
            {r_a, r_b} <= w_idx_nxt;
        end
    end

    // Stage 1: register the error of the pair presented this cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid_q <= 1'b0;
            r_err_q   <= '0;
        end else begin
            r_valid_q <= w_sample;
            if (w_sample) begin
                r_err_q <= w_err;
            end
        end
    end

    // Stage 2: accumulate, count and track the maximum
    sweep_err_accum #(
        .WIDTH      (WIDTH)
    ) u_accum (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (w_start_acc),
        .valid      (r_valid_q),
        .err        (r_err_q),
        .total_err  (total_err),
        .err_cases  (err_cases),
        .max_err    (max_err)
    );

    assign a_o  = r_a;
    assign b_o  = r_b;
    assign busy = (r_state == c_ST_SWEEP) || (r_state == c_ST_FLUSH);
    assign done = (r_state == c_ST_DONE);

endmodule : adder_error_sweeper

`default_nettype wire

// File: tb/tb_adder_error_sweeper.sv
// ============================================================================
// Module      : tb_adder_error_sweeper
// Description : Directed, table-driven bench for adder_error_sweeper at
//               WIDTH=2 (several adder models) and WIDTH=8 (LSB-cleared).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_error_sweeper;
    import adder_eval_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // ---------------- WIDTH = 2 instance ----------------
    logic       start2, stall2;
    logic [1:0] a2, b2;
    logic [2:0] approx2, sum2;
    logic       busy2, done2;
    logic [6:0] total2;
    logic [4:0] cases2;
    logic [2:0] max2;
    int         mode;   // 0: exact, 1: LSB cleared, 2: tied to zero

    adder_error_sweeper #(.WIDTH(2)) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start2),
        .stall        (stall2),
        .a_o          (a2),
        .b_o          (b2),
        .approx_sum_i (approx2),
        .busy         (busy2),
        .done         (done2),
        .total_err    (total2),
        .err_cases    (cases2),
        .max_err      (max2)
    );

    // Approximate adder models driven by the selected mode
    always_comb begin
        sum2 = {1'b0, a2} + {1'b0, b2};
        case (mode)
            0:       approx2 = sum2;
            1:       approx2 = sum2 & 3'b110;
            default: approx2 = 3'b000;
        endcase
    end

    // ---------------- WIDTH = 8 instance ----------------
    logic        start8, stall8;
    logic [7:0]  a8, b8;
    logic [8:0]  approx8, sum8;
    logic        busy8, done8;
    logic [24:0] total8;
    logic [16:0] cases8;
    logic [8:0]  max8;

    adder_error_sweeper #(.WIDTH(8)) u_dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start8),
        .stall        (stall8),
        .a_o          (a8),
        .b_o          (b8),
        .approx_sum_i (approx8),
        .busy         (busy8),
        .done         (done8),
        .total_err    (total8),
        .err_cases    (cases8),
        .max_err      (max8)
    );

    assign sum8    = {1'b0, a8} + {1'b0, b8};
    assign approx8 = {sum8[8:1], 1'b0};

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int mode;
        int nstall;
        int pulse_at;   // cycle after acceptance to re-pulse start, -1 none
        int exp_total;
        int exp_cases;
        int exp_max;
        int exp_lat;    // posedges from start driven until done seen
    } vec_t;

    localparam int c_NVEC = 6;
    vec_t vecs [c_NVEC];

    // One sweep on the WIDTH=2 instance, starting from IDLE or DONE
    task automatic run_sweep(input string tag, input int md, input int nstall,
                             input int pulse_at, input int et, input int ec,
                             input int em, input int el);
        logic [11:0] mask;
        int          lat;
        bit          got;
        logic [6:0]  t_snap;
        mask = '0;
        while ($countones(mask) < nstall) mask[$urandom_range(0, 11)] = 1'b1;
        @(posedge clk); #1;
        mode   = md;
        start2 = 1'b1;
        stall2 = 1'b0;
        lat = 0;
        got = 0;
        while (!got && lat < 200) begin
            @(posedge clk); lat++; #1;
            start2 = ((lat - 1) == pulse_at);
            stall2 = (lat - 1 < 12) ? mask[lat - 1] : 1'b0;
            @(negedge clk);
            if (lat == 1) check({tag, " busy_after_start"}, busy2, 1);
            if (done2) got = 1;
        end
        stall2 = 1'b0;
        start2 = 1'b0;
        check({tag, " latency"},   lat,    el);
        check({tag, " total_err"}, total2, et);
        check({tag, " err_cases"}, cases2, ec);
        check({tag, " max_err"},   max2,   em);
        check({tag, " a_hold"},    a2,     3);
        check({tag, " b_hold"},    b2,     3);
        t_snap = total2;
        repeat (3) @(negedge clk);
        check({tag, " done_stable"},  done2,  1);
        check({tag, " busy_low"},     busy2,  0);
        check({tag, " total_stable"}, total2, t_snap);
    endtask

    initial begin
        int lat8;

        vecs[0] = '{mode: 0, nstall: 0, pulse_at: -1, exp_total: 0,  exp_cases: 0,  exp_max: 0, exp_lat: 18};
        vecs[1] = '{mode: 1, nstall: 0, pulse_at: -1, exp_total: 8,  exp_cases: 8,  exp_max: 1, exp_lat: 18};
        vecs[2] = '{mode: 2, nstall: 0, pulse_at: -1, exp_total: 48, exp_cases: 15, exp_max: 6, exp_lat: 18};
        vecs[3] = '{mode: 1, nstall: 5, pulse_at: -1, exp_total: 8,  exp_cases: 8,  exp_max: 1, exp_lat: 23};
        vecs[4] = '{mode: 2, nstall: 3, pulse_at: -1, exp_total: 48, exp_cases: 15, exp_max: 6, exp_lat: 21};
        vecs[5] = '{mode: 1, nstall: 0, pulse_at: 5,  exp_total: 8,  exp_cases: 8,  exp_max: 1, exp_lat: 18};

        rst_n  = 1'b0;
        start2 = 1'b0; stall2 = 1'b0; mode = 0;
        start8 = 1'b0; stall8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy2",  busy2,  0);
        check("reset done2",  done2,  0);
        check("reset a2",     a2,     0);
        check("reset b2",     b2,     0);
        check("reset total2", total2, 0);
        check("reset cases2", cases2, 0);
        check("reset max2",   max2,   0);
        check("reset done8",  done8,  0);
        check("reset total8", total8, 0);
        #1 rst_n = 1'b1;

        // Table-driven sweeps; all but the first restart from DONE
        for (int i = 0; i < c_NVEC; i++) begin
            run_sweep($sformatf("vec%0d", i), vecs[i].mode, vecs[i].nstall,
                      vecs[i].pulse_at, vecs[i].exp_total, vecs[i].exp_cases,
                      vecs[i].exp_max, vecs[i].exp_lat);
        end

        // Abort a sweep with reset at SWEEP cycle 7
        @(posedge clk); #1;
        mode   = 2;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("midsweep busy", busy2, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort busy",  busy2,  0);
        check("abort done",  done2,  0);
        check("abort a",     a2,     0);
        check("abort b",     b2,     0);
        check("abort total", total2, 0);
        check("abort cases", cases2, 0);
        check("abort max",   max2,   0);
        rst_n = 1'b1;
        run_sweep("restart", 1, 0, -1, 8, 8, 1, 18);

        // WIDTH=8 LSB-cleared sweep
        @(posedge clk); #1;
        start8 = 1'b1;
        lat8 = 0;
        while (!done8 && lat8 < 70000) begin
            @(posedge clk); lat8++; #1;
            start8 = 1'b0;
            @(negedge clk);
        end
        check("w8 latency",   lat8,   65538);
        check("w8 total_err", total8, 32768);
        check("w8 err_cases", cases8, 32768);
        check("w8 max_err",   max8,   1);
        check("w8 a_hold",    a8,     255);
        check("w8 b_hold",    b8,     255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_adder_error_sweeper

`default_nettype wire
